// File: rtl/lr_sched_pkg.sv
// lr_sched_pkg
//   Shared definitions for the leaky-ReLU request scheduler:
//   - DATA_W: operand/result width (signed Q8.8)
//   - Q8.8 fixed-point constants
//   - lr_state_e: scheduler FSM states
//   - id_width(): width of a requester index, never below one bit
package lr_sched_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam logic signed [DATA_W-1:0] Q88_ONE  = 16'sh0100;
  localparam logic signed [DATA_W-1:0] Q88_ZERO = 16'sh0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } lr_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lr_sched_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin grant selection.
//   Ports:
//     req   - request vector, one bit per requester
//     ptr   - index of the most recent winner; the search starts at ptr+1
//     grant - one-hot grant (all zero when nothing is requested)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W-1:0] idx;

  // Walk from the farthest candidate to the nearest one after ptr, so the
  // last hit (the nearest requester in round-robin order) is the one kept.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lr_sched.sv
// lr_sched
//   Time-shares one leaky-ReLU unit between NUM_REQ requesters.
//   One operation is in flight at a time: IDLE (grant) -> ISSUE (drive unit)
//   -> WAIT (until unit result) -> IDLE, giving one result every 3 cycles at
//   best. Each requester has its own Q8.8 leak register, written via cfg_*.
//   Ports:
//     clk, rst          - clock, asynchronous active-low reset
//     clear             - synchronous abort back to IDLE (no response emitted)
//     req_valid/data    - per-requester request and signed operand
//     req_ready         - one-hot grant, only in IDLE
//     rsp_valid/id/data - one-cycle result strobe, requester index, result
//     cfg_we/addr/data  - leak register write port
//     lr_valid_in, lr_input, lr_leak - drive the leaky-ReLU unit
//     lr_out, lr_valid_out           - unit result
//   Optional: define LR_SCHED_PERF_EN to add output issue_count, a 32-bit
//   wrapping count of ISSUE cycles, zeroed by reset and by clear.
module lr_sched
  import lr_sched_pkg::*;
#(
  parameter int                        NUM_REQ      = 4,
  parameter logic signed [DATA_W-1:0]  DEFAULT_LEAK = 16'sh0003,
  localparam int                       ID_W         = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic signed [DATA_W-1:0] req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic signed [DATA_W-1:0] rsp_data,
  input  logic                     cfg_we,
  input  logic [ID_W-1:0]          cfg_addr,
  input  logic signed [DATA_W-1:0] cfg_data,
  output logic                     lr_valid_in,
  output logic signed [DATA_W-1:0] lr_input,
  output logic signed [DATA_W-1:0] lr_leak,
  input  logic signed [DATA_W-1:0] lr_out,
  input  logic                     lr_valid_out
`ifdef LR_SCHED_PERF_EN
  ,
  output logic [31:0]              issue_count
`endif
);

  lr_state_e                state;
  logic [ID_W-1:0]          last_grant;
  logic [ID_W-1:0]          cur_id;
  logic [ID_W-1:0]          grant_id;
  logic signed [DATA_W-1:0] cur_op;
  logic signed [DATA_W-1:0] leak_reg [NUM_REQ];
  logic [NUM_REQ-1:0]       grant;
  logic                     transfer;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (last_grant),
    .grant (grant)
  );

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  // The grant is withheld during reset and during clear so a requester never
  // sees a handshake that the FSM then throws away.
  assign req_ready = (rst && !clear && state == IDLE) ? grant : '0;
  assign transfer  = |req_ready;

  // The leak is read straight from its register during ISSUE; a cfg write in
  // that same cycle only lands at the closing edge, so the issue sees the old
  // value.
  assign lr_valid_in = (state == ISSUE);
  assign lr_input    = lr_valid_in ? cur_op : '0;
  assign lr_leak     = lr_valid_in ? leak_reg[cur_id] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      cur_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (clear) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (transfer) begin
              state      <= ISSUE;
              cur_op     <= req_data[grant_id];
              cur_id     <= grant_id;
              last_grant <= grant_id;
            end
          end
          ISSUE: state <= WAIT;
          WAIT: begin
            if (lr_valid_out) begin
              state     <= IDLE;
              rsp_valid <= 1'b1;
              rsp_id    <= cur_id;
              rsp_data  <= lr_out;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) leak_reg[i] <= DEFAULT_LEAK;
    end else if (cfg_we && int'(cfg_addr) < NUM_REQ) begin
      leak_reg[cfg_addr] <= cfg_data;
    end
  end

`ifdef LR_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_count <= '0;
    end else if (clear) begin
      issue_count <= '0;
    end else if (state == ISSUE) begin
      issue_count <= issue_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/lr_sched.md
LR_SCHED -- requirements
Module: lr_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one leaky-ReLU unit.
REQ-002 SHALL have parameter DEFAULT_LEAK, default 16'sh0003: reset value of every leak register, Q8.8.
REQ-003 SHALL have port clk, input, 1: single clock; all logic samples on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port clear, input, 1: synchronous abort; returns the FSM to IDLE.
REQ-006 SHALL have port req_valid, input, NUM_REQ: per-requester request.
REQ-007 SHALL have port req_data, input, NUM_REQ x 16 signed: per-requester operand.
REQ-008 SHALL have port req_ready, output, NUM_REQ: one-hot grant.
REQ-009 SHALL have port rsp_valid, output, 1: result strobe.
REQ-010 SHALL have port rsp_id, output, clog2(NUM_REQ): requester index of the result.
REQ-011 SHALL have port rsp_data, output, 16 signed: result value.
REQ-012 SHALL have port cfg_we, input, 1: leak register write enable.
REQ-013 SHALL have port cfg_addr, input, clog2(NUM_REQ): leak register index.
REQ-014 SHALL have port cfg_data, input, 16 signed: leak register write value.
REQ-015 SHALL have port lr_valid_in, output, 1: drives the unit's input valid.
REQ-016 SHALL have port lr_input, output, 16 signed: drives the unit's operand.
REQ-017 SHALL have port lr_leak, output, 16 signed: drives the unit's leak factor.
REQ-018 SHALL have port lr_out, input, 16 signed: unit result.
REQ-019 SHALL have port lr_valid_out, input, 1: unit result valid.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT; transitions IDLE->ISSUE on grant, ISSUE->WAIT unconditionally, WAIT->IDLE when lr_valid_out=1, otherwise stay in WAIT.
REQ-021 SHALL assert req_ready combinationally in IDLE only, for exactly one index with req_valid=1; the transfer occurs on req_valid&req_ready.
REQ-022 SHALL select the winner round-robin, starting the search at last_grant+1 mod NUM_REQ; last_grant updates on every transfer.
REQ-023 SHALL latch the operand and ID at transfer (cycle T).
REQ-024 SHALL drive lr_valid_in=1 only in ISSUE (cycle T+1), with the latched operand and leak_reg[id].
REQ-025 SHALL capture lr_out in WAIT and pulse rsp_valid for one cycle at T+3 with rsp_id/rsp_data; rsp_data SHALL hold its value until the next result.
REQ-026 SHALL NOT assert lr_valid_in on consecutive cycles (unit accepts only while its valid_out=0); peak throughput is one operation per 3 cycles.
REQ-027 SHALL apply a cfg_we write at the next edge; a write coinciding with ISSUE to the same index SHALL NOT affect that issue (old value used).
REQ-028 SHALL, on clear: go to IDLE, drop any in-flight result (no rsp_valid), keep leak registers and last_grant; clear SHALL have priority over every transition.
REQ-029 SHALL ignore lr_valid_out outside WAIT.

Reset
REQ-030 SHALL, while rst=0: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, lr_valid_in=0, lr_input=0, lr_leak=0, all leak registers=DEFAULT_LEAK, last_grant=NUM_REQ-1.
REQ-031 SHALL abort any in-flight operation on reset without emitting a response.

Configuration
REQ-032 SHALL, with LR_SCHED_PERF_EN defined, add output issue_count (32 bits): increments on every ISSUE cycle, wraps, resets to 0, cleared also by clear; without the macro, the port and counter SHALL be absent.

Structure
REQ-033 SHALL place the state enum, DATA_W=16 and Q8.8 constants in package lr_sched_pkg.
REQ-034 SHALL implement grant selection in sub-module rr_arbiter (req vector, pointer in, one-hot grant out).

Verification
REQ-035 Single request: req_valid[2]=1, data=16'sh0200, lr_out returns 16'sh0200 at T+2 -> rsp_valid at T+3, rsp_id=2, rsp_data=16'sh0200, lr_valid_in high only at T+1.
REQ-036 All four requesting continuously from reset -> grant order 0,1,2,3,0; transfers spaced 3 cycles; lr_valid_in never high on two consecutive cycles.
REQ-037 cfg write leak[1]=16'sh0040, then request 1 with -16'sh0100 -> lr_leak=16'sh0040 during ISSUE; a write in the ISSUE cycle -> old value driven.
REQ-038 clear asserted in WAIT -> IDLE next cycle, no rsp_valid, next request serviced normally.
REQ-039 rst low mid-WAIT -> all outputs reset immediately; leak registers read back DEFAULT_LEAK via issued lr_leak.
REQ-040 (LR_SCHED_PERF_EN) 5 operations -> issue_count=5; after clear -> 0.
